// File: rtl/uart_echo_buffered.sv
// uart_echo_buffered
//
// Serial loopback and diagnostics block. Frames received on rx are
// deserialised, checked for framing and parity problems and stored in a
// circular FIFO. A transmitter drains the FIFO and retransmits each word
// unchanged on tx. Problems are recorded in sticky flags.
//
// Parameters
//   TICK_DIVISOR     clocks per 16x oversample tick
//   DATA_BITS        data bits per frame (5..9)
//   PARITY           0 none, 1 odd, 2 even
//   STOP_BITS        stop bits generated by the transmitter (1 or 2)
//   FIFO_DEPTH_LOG2  FIFO holds 2**FIFO_DEPTH_LOG2 words
//
// Ports
//   clock         system clock, rising edge
//   reset         synchronous, active-low reset
//   rx            asynchronous serial input, idles high
//   tx_hold       while high the transmitter does not start a new frame
//   clear_errors  one-cycle pulse clearing the sticky flags
//   tx            serial output, idles high
//   tx_busy       transmitter is not idle
//   fifo_count    words currently buffered
//   frame_error   sticky: a stop bit was sampled low
//   parity_error  sticky: a parity mismatch was seen
//   overflow      sticky: a word was dropped because the FIFO was full
//
// RX FSM
//   state     | meaning
//   RX_IDLE   | waiting for a low rx at a tick
//   RX_START  | checking the start bit at its centre
//   RX_DATA   | sampling DATA_BITS data bits, LSB first
//   RX_PARITY | sampling the parity bit
//   RX_STOP   | sampling the first stop bit, then push or discard
//
// TX FSM
//   state     | meaning
//   TX_IDLE   | waiting for a buffered word and tx_hold low
//   TX_START  | driving the start bit
//   TX_DATA   | driving data bits, LSB first
//   TX_PARITY | driving the parity bit
//   TX_STOP   | driving STOP_BITS stop bits

module uart_echo_buffered #(
    parameter int TICK_DIVISOR    = 163,
    parameter int DATA_BITS       = 8,
    parameter int PARITY          = 0,
    parameter int STOP_BITS       = 1,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       rx,
    input  logic                       tx_hold,
    input  logic                       clear_errors,
    output logic                       tx,
    output logic                       tx_busy,
    output logic [FIFO_DEPTH_LOG2:0]   fifo_count,
    output logic                       frame_error,
    output logic                       parity_error,
    output logic                       overflow
);

    localparam int TW    = (TICK_DIVISOR > 1) ? $clog2(TICK_DIVISOR) : 1;
    localparam int CW    = FIFO_DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIVISOR - 1);
    localparam logic [3:0]    LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic [5:0]    STOP_LAST = 6'(STOP_BITS * 16 - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

    // ------------------------------------------------------------------
    // Oversample tick, shared by both directions
    // ------------------------------------------------------------------
    logic [TW-1:0] tick_cnt;
    logic          tick;

    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clock) begin
        if (!reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // rx synchroniser, resets to the idle level
    // ------------------------------------------------------------------
    logic rx_meta;
    logic rx_sync;

    always_ff @(posedge clock) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    rx_state_t             rx_state, rx_state_nxt;
    logic [3:0]            rx_tcnt, rx_tcnt_nxt;
    logic [3:0]            rx_bcnt, rx_bcnt_nxt;
    logic [DATA_BITS-1:0]  rx_shift, rx_shift_nxt;
    logic                  rx_bad, rx_bad_nxt;
    logic                  rx_par_exp;
    logic                  push;
    logic                  frame_set;
    logic                  parity_set;

    // Value the parity bit must carry for the word just received.
    assign rx_par_exp = (PARITY == 1) ? ~(^rx_shift) : (^rx_shift);

    always_ff @(posedge clock) begin
        if (!reset) begin
            rx_state <= RX_IDLE;
            rx_tcnt  <= '0;
            rx_bcnt  <= '0;
            rx_shift <= '0;
            rx_bad   <= 1'b0;
        end else begin
            rx_state <= rx_state_nxt;
            rx_tcnt  <= rx_tcnt_nxt;
            rx_bcnt  <= rx_bcnt_nxt;
            rx_shift <= rx_shift_nxt;
            rx_bad   <= rx_bad_nxt;
        end
    end

    always_comb begin
        rx_state_nxt = rx_state;
        rx_tcnt_nxt  = rx_tcnt;
        rx_bcnt_nxt  = rx_bcnt;
        rx_shift_nxt = rx_shift;
        rx_bad_nxt   = rx_bad;
        push         = 1'b0;
        frame_set    = 1'b0;
        parity_set   = 1'b0;

        if (tick) begin
            rx_tcnt_nxt = rx_tcnt + 4'd1;
            case (rx_state)
                RX_IDLE: begin
                    rx_tcnt_nxt = '0;
                    if (!rx_sync) begin
                        rx_state_nxt = RX_START;
                        rx_bcnt_nxt  = '0;
                        rx_bad_nxt   = 1'b0;
                    end
                end
                RX_START: begin
                    // Centre of the start bit; a high line here was a glitch.
                    if (rx_tcnt == 4'd7) begin
                        rx_tcnt_nxt  = '0;
                        rx_state_nxt = rx_sync ? RX_IDLE : RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (rx_tcnt == 4'd15) begin
                        rx_shift_nxt = {rx_sync, rx_shift[DATA_BITS-1:1]};
                        if (rx_bcnt == LAST_BIT) begin
                            rx_state_nxt = (PARITY != 0) ? RX_PARITY : RX_STOP;
                        end else begin
                            rx_bcnt_nxt = rx_bcnt + 4'd1;
                        end
                    end
                end
                RX_PARITY: begin
                    if (rx_tcnt == 4'd15) begin
                        rx_bad_nxt   = (rx_sync != rx_par_exp);
                        rx_state_nxt = RX_STOP;
                    end
                end
                RX_STOP: begin
                    // Only the first stop bit is checked; any further stop
                    // bits are simply idle line to the receiver.
                    if (rx_tcnt == 4'd15) begin
                        rx_state_nxt = RX_IDLE;
                        if (!rx_sync) begin
                            frame_set = 1'b1;
                        end else if (rx_bad) begin
                            parity_set = 1'b1;
                        end else begin
                            push = 1'b1;
                        end
                    end
                end
                default: rx_state_nxt = RX_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0]       mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
    logic [CW-1:0]              count;
    logic                       full;
    logic                       pop;
    logic                       wr_en;
    logic                       overflow_set;
    logic [DATA_BITS-1:0]       head;

    assign full         = (count == FULL_CNT);
    // A simultaneous pop frees a slot, so a full FIFO still accepts the word.
    assign wr_en        = push && (!full || pop);
    assign overflow_set = push && full && !pop;
    assign head         = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr] <= rx_shift;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    tx_state_t             tx_state, tx_state_nxt;
    logic [5:0]            tx_tcnt, tx_tcnt_nxt;
    logic [3:0]            tx_bcnt, tx_bcnt_nxt;
    logic [DATA_BITS-1:0]  tx_data, tx_data_nxt;
    logic                  tx_par, tx_par_nxt;
    logic                  tx_bit, tx_bit_nxt;

    always_ff @(posedge clock) begin
        if (!reset) begin
            tx_state <= TX_IDLE;
            tx_tcnt  <= '0;
            tx_bcnt  <= '0;
            tx_data  <= '0;
            tx_par   <= 1'b0;
            tx_bit   <= 1'b1;
        end else begin
            tx_state <= tx_state_nxt;
            tx_tcnt  <= tx_tcnt_nxt;
            tx_bcnt  <= tx_bcnt_nxt;
            tx_data  <= tx_data_nxt;
            tx_par   <= tx_par_nxt;
            tx_bit   <= tx_bit_nxt;
        end
    end

    always_comb begin
        tx_state_nxt = tx_state;
        tx_tcnt_nxt  = tx_tcnt;
        tx_bcnt_nxt  = tx_bcnt;
        tx_data_nxt  = tx_data;
        tx_par_nxt   = tx_par;
        tx_bit_nxt   = tx_bit;
        pop          = 1'b0;

        if (tick) begin
            tx_tcnt_nxt = tx_tcnt + 6'd1;
            case (tx_state)
                TX_IDLE: begin
                    tx_tcnt_nxt = '0;
                    tx_bit_nxt  = 1'b1;
                    if ((count != '0) && !tx_hold) begin
                        pop          = 1'b1;
                        tx_data_nxt  = head;
                        tx_par_nxt   = (PARITY == 1) ? ~(^head) : (^head);
                        tx_bit_nxt   = 1'b0;
                        tx_state_nxt = TX_START;
                    end
                end
                TX_START: begin
                    if (tx_tcnt == 6'd15) begin
                        tx_tcnt_nxt  = '0;
                        tx_bcnt_nxt  = '0;
                        tx_bit_nxt   = tx_data[0];
                        tx_state_nxt = TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (tx_tcnt == 6'd15) begin
                        tx_tcnt_nxt = '0;
                        if (tx_bcnt == LAST_BIT) begin
                            if (PARITY != 0) begin
                                tx_bit_nxt   = tx_par;
                                tx_state_nxt = TX_PARITY;
                            end else begin
                                tx_bit_nxt   = 1'b1;
                                tx_state_nxt = TX_STOP;
                            end
                        end else begin
                            tx_bcnt_nxt = tx_bcnt + 4'd1;
                            tx_data_nxt = tx_data >> 1;
                            tx_bit_nxt  = tx_data[1];
                        end
                    end
                end
                TX_PARITY: begin
                    if (tx_tcnt == 6'd15) begin
                        tx_tcnt_nxt  = '0;
                        tx_bit_nxt   = 1'b1;
                        tx_state_nxt = TX_STOP;
                    end
                end
                TX_STOP: begin
                    if (tx_tcnt == STOP_LAST) begin
                        tx_tcnt_nxt  = '0;
                        tx_bit_nxt   = 1'b1;
                        tx_state_nxt = TX_IDLE;
                    end
                end
                default: begin
                    tx_bit_nxt   = 1'b1;
                    tx_state_nxt = TX_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sticky flags: a set in the same cycle as a clear wins
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            frame_error  <= 1'b0;
            parity_error <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            frame_error  <= frame_set    | (frame_error  & ~clear_errors);
            parity_error <= parity_set   | (parity_error & ~clear_errors);
            overflow     <= overflow_set | (overflow     & ~clear_errors);
        end
    end

    assign tx         = tx_bit;
    assign tx_busy    = (tx_state != TX_IDLE);
    assign fifo_count = count;

endmodule

// File: tb/tb_uart_echo_buffered.sv
`timescale 1ns/1ps

module tb_uart_echo_buffered;

    logic       clock = 1'b0;
    logic       reset;
    logic       rx;
    logic       rx_p;
    logic       tx_hold;
    logic       clear_errors;

    logic       tx, tx_busy, frame_error, parity_error, overflow;
    logic [4:0] fifo_count;
    logic       tx_p, tx_busy_p, frame_error_p, parity_error_p, overflow_p;
    logic [4:0] fifo_count_p;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    uart_echo_buffered #(.TICK_DIVISOR(2)) dut (
        .clock(clock), .reset(reset), .rx(rx), .tx_hold(tx_hold),
        .clear_errors(clear_errors), .tx(tx), .tx_busy(tx_busy),
        .fifo_count(fifo_count), .frame_error(frame_error),
        .parity_error(parity_error), .overflow(overflow)
    );

    uart_echo_buffered #(.TICK_DIVISOR(2), .PARITY(2)) dut_p (
        .clock(clock), .reset(reset), .rx(rx_p), .tx_hold(tx_hold),
        .clear_errors(clear_errors), .tx(tx_p), .tx_busy(tx_busy_p),
        .fifo_count(fifo_count_p), .frame_error(frame_error_p),
        .parity_error(parity_error_p), .overflow(overflow_p)
    );

    // Decoded echoes: {stop, data} for the 8N1 instance,
    // {stop, parity, data} for the even-parity instance.
    logic [8:0] mon_q[$];
    time        mon_t[$];
    logic [9:0] mon_p_q[$];

    initial begin : mon0
        logic [7:0] w;
        logic       st;
        time        t0;
        forever begin
            @(negedge clock);
            if (reset && tx == 1'b0) begin
                t0 = $time;
                repeat (16) @(negedge clock);
                if (tx == 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (32) @(negedge clock);
                        w[i] = tx;
                    end
                    repeat (32) @(negedge clock);
                    st = tx;
                    mon_q.push_back({st, w});
                    mon_t.push_back(t0);
                end
            end
        end
    end

    initial begin : mon1
        logic [7:0] w;
        logic       pb;
        logic       st;
        forever begin
            @(negedge clock);
            if (reset && tx_p == 1'b0) begin
                repeat (16) @(negedge clock);
                if (tx_p == 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (32) @(negedge clock);
                        w[i] = tx_p;
                    end
                    repeat (32) @(negedge clock);
                    pb = tx_p;
                    repeat (32) @(negedge clock);
                    st = tx_p;
                    mon_p_q.push_back({st, pb, w});
                end
            end
        end
    end

    logic [4:0] peak;
    logic       peak_clr = 1'b0;
    always @(negedge clock) begin
        if (peak_clr) peak = '0;
        else if (fifo_count > peak) peak = fifo_count;
    end

    time  last_fall = 0;
    logic tx_prev = 1'b1;
    always @(negedge clock) begin
        if (tx_prev && !tx) last_fall = $time;
        tx_prev = tx;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int line, input logic b, input int n);
        if (line == 0) rx = b;
        else rx_p = b;
        repeat (n) @(negedge clock);
    endtask

    task automatic send_frame(input int line, input logic [7:0] d, input bit par_en,
                              input logic par_bit, input logic stop_ok);
        drive(line, 1'b0, 32);
        for (int i = 0; i < 8; i++) drive(line, d[i], 32);
        if (par_en) drive(line, par_bit, 32);
        if (stop_ok) begin
            drive(line, 1'b1, 32);
        end else begin
            // Low across the stop sample only, so the tail does not
            // look like the start of another frame.
            drive(line, 1'b0, 24);
            drive(line, 1'b1, 8);
        end
    endtask

    task automatic wait_q(input int want, input int limit);
        for (int i = 0; i < limit && mon_q.size() < want; i++) @(negedge clock);
    endtask

    task automatic pulse_clear();
        @(negedge clock);
        clear_errors = 1'b1;
        @(negedge clock);
        clear_errors = 1'b0;
        @(negedge clock);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop_ok;
        logic       exp_echo;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[5];
    time  send_t;
    time  lat;
    int   n_wait;

    initial begin
        vecs[0] = '{8'h00, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{8'hA5, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'h3C, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{8'h5A, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{8'hC3, 1'b1, 1'b1, 1'b0};

        reset = 1'b0; rx = 1'b1; rx_p = 1'b1; tx_hold = 1'b0; clear_errors = 1'b0;
        repeat (10) @(negedge clock);
        check("reset_tx", tx, 1);
        check("reset_tx_busy", tx_busy, 0);
        check("reset_fifo_count", fifo_count, 0);
        check("reset_flags", {frame_error, parity_error, overflow}, 0);
        check("reset_tx_p", tx_p, 1);
        reset = 1'b1;
        repeat (500) @(negedge clock);
        check("idle_no_echo", mon_q.size(), 0);
        check("idle_tx_high", tx, 1);
        check("idle_fifo_count", fifo_count, 0);

        @(posedge clock) peak_clr = 1'b1;
        @(posedge clock) peak_clr = 1'b0;

        for (int v = 0; v < 5; v++) begin
            mon_q.delete();
            mon_t.delete();
            @(negedge clock);
            send_t = $time;
            send_frame(0, vecs[v].data, 1'b0, 1'b0, vecs[v].stop_ok);
            if (vecs[v].exp_echo) begin
                wait_q(1, 600);
                check($sformatf("vec%0d_echo_count", v), mon_q.size(), 1);
                if (mon_q.size() > 0) begin
                    check($sformatf("vec%0d_echo_word", v), mon_q[0], {1'b1, vecs[v].data});
                    lat = mon_t[0] - send_t;
                    check($sformatf("vec%0d_latency_ok(%0t)", v, lat),
                          (lat >= 3070 && lat <= 3120), 1);
                end
            end else begin
                repeat (600) @(negedge clock);
                check($sformatf("vec%0d_no_echo", v), mon_q.size(), 0);
            end
            check($sformatf("vec%0d_frame_error", v), frame_error, vecs[v].exp_ferr);
            check($sformatf("vec%0d_fifo_count", v), fifo_count, 0);
            if (vecs[v].exp_ferr) begin
                pulse_clear();
                check($sformatf("vec%0d_frame_error_cleared", v), frame_error, 0);
            end
        end
        check("fifo_peak", peak, 1);

        // Fill past capacity while held.
        mon_q.delete();
        mon_t.delete();
        @(negedge clock);
        tx_hold = 1'b1;
        for (int k = 1; k <= 17; k++) send_frame(0, 8'(k), 1'b0, 1'b0, 1'b1);
        repeat (100) @(negedge clock);
        check("hold_fifo_count", fifo_count, 16);
        check("hold_overflow", overflow, 1);
        check("hold_no_echo", mon_q.size(), 0);
        check("hold_tx_idle", tx_busy, 0);
        tx_hold = 1'b0;
        wait_q(16, 8000);
        repeat (600) @(negedge clock);
        check("drain_count", mon_q.size(), 16);
        for (int k = 0; k < mon_q.size(); k++)
            check($sformatf("drain_word%0d", k), mon_q[k], {1'b1, 8'(k + 1)});
        check("drain_fifo_empty", fifo_count, 0);
        pulse_clear();
        check("overflow_cleared", overflow, 0);

        // Even parity instance: 0x07 has three ones, so parity bit must be 1.
        @(negedge clock);
        send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
        repeat (700) @(negedge clock);
        check("par_bad_flag", parity_error_p, 1);
        check("par_bad_no_echo", mon_p_q.size(), 0);
        pulse_clear();
        check("par_flag_cleared", parity_error_p, 0);
        send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 700 && mon_p_q.size() < 1; i++) @(negedge clock);
        check("par_good_echo_count", mon_p_q.size(), 1);
        if (mon_p_q.size() > 0) check("par_good_echo_word", mon_p_q[0], 10'h307);
        check("par_good_no_flag", parity_error_p, 0);

        // Reset in the middle of an echo, during data bit 3.
        mon_q.delete();
        mon_t.delete();
        @(negedge clock);
        send_t = $time;
        send_frame(0, 8'hFF, 1'b0, 1'b0, 1'b1);
        check("rst_echo_started", last_fall > send_t, 1);
        n_wait = int'((last_fall + 1440 - $time) / 10);
        if (n_wait > 0) repeat (n_wait) @(negedge clock);
        check("rst_busy_before", tx_busy, 1);
        reset = 1'b0;
        @(negedge clock);
        check("rst_tx_high", tx, 1);
        check("rst_tx_idle", tx_busy, 0);
        check("rst_fifo_count", fifo_count, 0);
        reset = 1'b1;
        repeat (400) @(negedge clock);
        mon_q.delete();
        mon_t.delete();
        send_frame(0, 8'h96, 1'b0, 1'b0, 1'b1);
        wait_q(1, 600);
        check("post_rst_echo_count", mon_q.size(), 1);
        if (mon_q.size() > 0) check("post_rst_echo_word", mon_q[0], 9'h196);

        // Short low glitch on rx.
        repeat (100) @(negedge clock);
        mon_q.delete();
        rx = 1'b0;
        repeat (4) @(negedge clock);
        rx = 1'b1;
        repeat (600) @(negedge clock);
        check("glitch_fifo_count", fifo_count, 0);
        check("glitch_no_echo", mon_q.size(), 0);
        check("glitch_flags", {frame_error, parity_error, overflow}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_echo_buffered.md
Name: uart_echo_buffered

Overview:
- Parametrised successor to the UART echo test block.
- Receives serial frames on rx, buffers the data words in a FIFO, and retransmits them unchanged on tx.
- Adds configurable word width, parity, stop-bit count and FIFO depth, plus transmit flow control and sticky error flags.
- Sits at the board-level serial pins as the loopback and diagnostics block.

Parameters:
- TICK_DIVISOR, 163: clocks per 16x oversample tick (bit time = 16*TICK_DIVISOR clocks).
- DATA_BITS, 8: data bits per frame, legal range 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: stop bits generated by TX, 1 or 2.
- FIFO_DEPTH_LOG2, 4: FIFO holds 2**FIFO_DEPTH_LOG2 words.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- rx  in  1  asynchronous serial input; idles high.
- tx_hold  in  1  while 1, TX does not start a new frame.
- clear_errors  in  1  one-cycle pulse that clears the sticky flags.
- tx  out  1  serial output; idles high.
- tx_busy  out  1  1 while TX is in any state other than IDLE.
- fifo_count  out  FIFO_DEPTH_LOG2+1  words currently buffered.
- frame_error  out  1  sticky; set when a stop bit is sampled low.
- parity_error  out  1  sticky; set on a parity mismatch.
- overflow  out  1  sticky; set when a word is dropped because the FIFO is full.

Behaviour:
- Reset (reset == 0 at a clock edge):
  - tx = 1, tx_busy = 0, fifo_count = 0, all flags = 0.
  - Both FSMs go to IDLE; tick counter = 0; rx synchroniser flops = 1.
  - Applies mid-frame: any partial RX word and any in-flight TX frame are abandoned, and tx returns high on the next edge.
- Tick generator:
  - Counter runs 0..TICK_DIVISOR-1 and wraps.
  - tick is high for one clock when the counter equals TICK_DIVISOR-1.
  - Free-running, shared by RX and TX.
- rx synchroniser: two flops; the RX FSM sees only the synchronised value.
- RX FSM (IDLE, START, DATA, PARITY, STOP); per-state tick counter 0..15:
  - IDLE: synchronised rx == 0 at a tick -> START, tick counter cleared.
  - START: at the 8th tick, rx == 0 -> DATA; rx == 1 -> IDLE (glitch rejected, no flag).
  - DATA: sample every 16 ticks, LSB first, DATA_BITS samples. Then -> PARITY if PARITY != 0, else -> STOP.
  - PARITY: sample after 16 ticks and compare against odd/even parity of the data; mismatch marks the word bad.
  - STOP: sample after 16 ticks. Only the first stop bit is checked; RX is back in IDLE immediately after that sample.
  - Stop sampled 0: set frame_error, discard the word.
  - Parity bad: set parity_error, discard the word.
  - Otherwise push the word to the FIFO for one cycle.
- FIFO:
  - Circular buffer of DATA_BITS-wide words; pointers wrap modulo depth.
  - fifo_count is updated on the cycle after the push/pop edge.
  - Push while full and no pop in the same cycle: word dropped, overflow set, contents unchanged.
  - Push and pop in the same cycle: both take effect, fifo_count unchanged; this also holds when full.
  - Pop while empty never occurs (TX pops only when non-empty).
- TX FSM (IDLE, START, DATA, PARITY, STOP); each bit lasts 16 ticks:
  - IDLE: fifo_count != 0 and tx_hold == 0 at a tick -> pop the head into the shift register, drive tx = 0, enter START.
  - START -> DATA (LSB first) -> PARITY (only if enabled) -> STOP.
  - STOP: STOP_BITS*16 ticks of tx = 1, then -> IDLE.
  - tx_hold asserted mid-frame does not affect the frame in progress.
  - Back-to-back frames: the next start bit begins on the tick following the end of the stop bits.
- Sticky flags:
  - clear_errors == 1 clears all three flags.
  - A set event in the same cycle as clear_errors wins: the flag ends up 1.
- Latency: the first echoed start bit begins at most one tick after the received stop-bit sample, provided tx_hold == 0.

Test Plan:
- Bench configuration: TICK_DIVISOR=2 (bit = 32 clocks), defaults otherwise.
- Reset held low 10 clocks, rx = 1 -> tx = 1, tx_busy = 0, fifo_count = 0, all flags 0; idle 500 clocks with no activity.
- Send 0x00 then 0xA5 (8N1) -> tx reproduces 0x00 then 0xA5 bit-exact. Each echo starts within 2 ticks of the received stop sample; fifo_count peaks at 1.
- tx_hold = 1, send 17 words 0x01..0x11 -> fifo_count = 16 and overflow = 1. Release tx_hold -> 0x01..0x10 echoed in order and 0x11 absent.
- Send 0x3C with the stop bit driven 0 -> frame_error = 1, nothing echoed. Pulse clear_errors -> flag returns to 0.
- PARITY=2: send 0x07 with parity bit 0 -> parity_error = 1, dropped. Send 0x07 with parity bit 1 -> echoed with tx parity bit 1.
- Assert reset for 1 cycle during TX data bit 3 of 0xFF -> tx = 1 on the next edge, fifo_count = 0, TX in IDLE; the next received word echoes normally.
- 4-cycle low glitch on rx -> no word pushed, no flag set.
